// File: rtl/serial_add_pkg.sv
// Shared encodings and sizing helpers for the bit-serial add sequencer.
package serial_add_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Step counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// 1-bit full adder cell shared by the serial add sequencer.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: operands shift LSB-first through one full_adder, sum built MSB-in.
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;

    full_adder u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .cin   (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_comb begin
        sum_next            = sum_sh >> 1;
        sum_next[WIDTH-1]   = fa_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        sum_sh <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_next;
                    carry  <= fa_carry;
                    // Hold cnt on the last step so it never wraps within an operation.
                    if (cnt != LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (abort) begin
                        state <= IDLE;
                    end else if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (abort || out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);
    // Datapath regs survive an abort, so results are only exposed in DONE.
    assign sum       = out_valid ? sum_sh : '0;
    assign cout      = out_valid & carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1 against a latency/arithmetic model.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst_n;

    logic       iv8, ir8, c8, ab8, ov8, or8, co8, bs8;
    logic [7:0] a8, b8, s8;
    logic       iv1, ir1, c1, ab1, ov1, or1, co1, bs1;
    logic [0:0] a1, b1, s1;

    int checks = 0;
    int errors = 0;

    // Model: a pending operation plus the cycles left before its result shows.
    bit          pend [2];
    int          rem  [2];
    logic [64:0] res  [2];

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(c8), .abort(ab8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8),
        .busy(bs8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .cin(c1), .abort(ab1), .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1),
        .busy(bs1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic mstep(input int i, input int w, input logic iv, input logic [63:0] a,
                         input logic [63:0] b, input logic c, input logic ab, input logic ordy);
        if (pend[i] && ab) begin
            pend[i] = 1'b0;
        end else if (pend[i] && rem[i] == 0) begin
            if (ordy) pend[i] = 1'b0;
        end else if (pend[i]) begin
            rem[i] = rem[i] - 1;
        end else if (iv) begin
            pend[i] = 1'b1;
            rem[i]  = w;
            res[i]  = {1'b0, a} + {1'b0, b} + 65'(c);
        end
    endtask

    function automatic logic [67:0] mexp(input int i, input int w);
        logic [64:0] mask;
        logic        v;
        mask = (65'd1 << w) - 65'd1;
        v    = pend[i] && (rem[i] == 0);
        return {~pend[i], v, pend[i], v ? res[i][w] : 1'b0, v ? 64'(res[i] & mask) : 64'd0};
    endfunction

    initial begin
        pend[0] = 1'b0; pend[1] = 1'b0;
        rem[0]  = 0;    rem[1]  = 0;
        res[0]  = '0;   res[1]  = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pend[0] = 1'b0;
                pend[1] = 1'b0;
            end else begin
                mstep(0, 8, iv8, 64'(a8), 64'(b8), c8, ab8, or8);
                mstep(1, 1, iv1, 64'(a1), 64'(b1), c1, ab1, or1);
            end
            #2;
            chk("model_w8", {ir8, ov8, bs8, co8, 64'(s8)}, mexp(0, 8));
            chk("model_w1", {ir1, ov1, bs1, co1, 64'(s1)}, mexp(1, 1));
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec, input int hold);
        int lat;
        @(negedge clk);
        a8 = a; b8 = b; c8 = c; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("lat8", 68'(lat), 68'd8);
        chk("sum8", 68'(s8), 68'(es));
        chk("cout8", 68'(co8), 68'(ec));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold", {ir8, ov8, co8, s8}, {1'b0, 1'b1, ec, es});
        end
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        chk("idle_after_pop", {ir8, ov8, bs8}, 3'b100);
    endtask

    initial begin
        int lat;
        bit seen;
        rst_n = 1'b0;
        iv8 = 0; c8 = 0; ab8 = 0; or8 = 0; a8 = '0; b8 = '0;
        iv1 = 0; c1 = 0; ab1 = 0; or1 = 0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        chk("reset_w8", {ir8, ov8, bs8, co8, s8}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        rst_n = 1'b1;

        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        op8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 0);
        op8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0);
        op8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 5);

        // Reset in the middle of RUN.
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h44; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk("async_reset", {ir8, ov8, bs8, co8, s8}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        op8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 0);

        // Abort in RUN: no result must ever appear.
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h0F; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        repeat (3) @(negedge clk);
        ab8 = 1'b1; or8 = 1'b1;
        @(negedge clk);
        ab8 = 1'b0;
        chk("abort_run", {ir8, ov8, bs8}, 3'b100);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ov8) seen = 1'b1;
        end
        chk("abort_no_valid", 68'(seen), 68'd0);
        or8 = 1'b0;

        // Abort in DONE beats the out_ready handshake.
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h02; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("done_reached", 68'(ov8), 68'd1);
        ab8 = 1'b1; or8 = 1'b1;
        @(negedge clk);
        ab8 = 1'b0; or8 = 1'b0;
        chk("abort_done", {ir8, ov8, co8, s8}, {1'b1, 1'b0, 1'b0, 8'h00});

        // WIDTH=1 single-step result.
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; iv1 = 1'b1;
        @(negedge clk);
        iv1 = 1'b0;
        lat = 0;
        while (!ov1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("lat1", 68'(lat), 68'd1);
        chk("w1_result", {co1, s1}, 2'b11);
        or1 = 1'b1;
        @(negedge clk);
        or1 = 1'b0;

        // Random traffic on both instances, including back-to-back and backpressure.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            iv8 = 1'($urandom);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            c8  = 1'($urandom);
            ab8 = ($urandom_range(0, 31) == 0);
            or8 = ($urandom_range(0, 3) != 0);
            iv1 = ($urandom_range(0, 7) != 0);
            a1  = 1'($urandom);
            b1  = 1'($urandom);
            c1  = 1'($urandom);
            ab1 = ($urandom_range(0, 31) == 0);
            or1 = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        iv8 = 0; ab8 = 0; or8 = 1;
        iv1 = 0; ab1 = 0; or1 = 1;
        repeat (20) @(negedge clk);
        chk("drained", {ir8, bs8, ir1, bs1}, 4'b1010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
